axi_aw_arbiter: RTL and testbench



---
 rtl/axi_arb_pkg.sv | 31 +++
 rtl/axi_grant_fifo.sv | 79 +++++++
 rtl/axi_aw_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_axi_aw_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// ============================================================================
//  Module      : axi_arb_pkg
//  Description : Shared types and constants for the AXI channel arbiters.
//                Holds the AXI response codes, the output-stage state
//                encoding and the requester index width helper.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package axi_arb_pkg;

   // AXI BRESP / RRESP encodings
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] EXOKAY = 2'b01;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // Registered output stage occupancy
   typedef enum logic [0:0] {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

   // Width needed to index n items, never less than one bit
   function automatic int calc_idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/axi_grant_fifo.sv
// ============================================================================
//  Module      : axi_grant_fifo
//  Description : Small FIFO recording the order in which requesters were
//                granted, so the data channel can be steered per burst.
//                Pushes while full and pops while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_grant_fifo
   import axi_arb_pkg::*;
#(
   parameter  int WIDTH = 2,
   parameter  int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             push_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic [CNT_W-1:0] count_o,
   output logic             full_o
);

   localparam int PTR_W = calc_idx_w(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign full_o    = (r_count == CNT_W'(DEPTH));
   assign w_do_push = push_i && !full_o;
   assign w_do_pop  = pop_i && (r_count != '0);
   assign head_o    = r_mem[r_rd_ptr];
   assign count_o   = r_count;

   // Storage array and write pointer
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
      end else if (w_do_push) begin
         r_mem[r_wr_ptr] <= data_i;
         r_wr_ptr        <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
   end

   // Read pointer advances on every accepted pop
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rd_ptr <= '0;
      end else if (w_do_pop) begin
         r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
   end

   // Occupancy count; push and pop together leave it unchanged
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_count <= '0;
      end else begin
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: rtl/axi_aw_arbiter.sv
// ============================================================================
//  Module      : axi_aw_arbiter
//  Description : Round-robin arbiter sharing one AXI4 AW channel between
//                NUM_SLV requesters. Registered output stage, requester
//                index prepended to AWID, and a grant-order FIFO driving the
//                W-channel select.
//                Optional: define AXI_AW_ARB_QOS_EN for highest-QoS-first
//                arbitration with round-robin tie break.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module axi_aw_arbiter
   import axi_arb_pkg::*;
#(
   parameter  int NUM_SLV         = 4,
   parameter  int ADDRESS_WIDTH   = 32,
   parameter  int ID_WIDTH        = 16,
   parameter  int MAX_OUTSTANDING = 4,
   localparam int IDX_W           = calc_idx_w(NUM_SLV)
) (
   input  logic                          clk_i,
   input  logic                          rst_ni,
   input  logic [NUM_SLV-1:0]            slv_aw_valid_i,
   input  logic [NUM_SLV*ADDRESS_WIDTH-1:0] slv_aw_addr_i,
   input  logic [NUM_SLV*8-1:0]          slv_aw_len_i,
   input  logic [NUM_SLV*ID_WIDTH-1:0]   slv_aw_id_i,
`ifdef AXI_AW_ARB_QOS_EN
   input  logic [NUM_SLV*4-1:0]          slv_aw_qos_i,
   output logic [3:0]                    mst_aw_qos_o,
`endif
   output logic [NUM_SLV-1:0]            slv_aw_ready_o,
   output logic                          mst_aw_valid_o,
   output logic [ADDRESS_WIDTH-1:0]      mst_aw_addr_o,
   output logic [7:0]                    mst_aw_len_o,
   output logic [IDX_W+ID_WIDTH-1:0]     mst_aw_id_o,
   input  logic                          mst_aw_ready_i,
   output logic [IDX_W-1:0]              w_sel_o,
   output logic                          w_sel_valid_o,
   input  logic                          w_last_hs_i
);

   localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

   out_state_e                r_state;
   out_state_e                w_state_d;
   logic [IDX_W-1:0]          r_rr_ptr;
   logic [ADDRESS_WIDTH-1:0]  r_addr;
   logic [7:0]                r_len;
   logic [IDX_W+ID_WIDTH-1:0] r_id;

   logic [ADDRESS_WIDTH-1:0]  w_addr [NUM_SLV];
   logic [7:0]                w_len  [NUM_SLV];
   logic [ID_WIDTH-1:0]       w_id   [NUM_SLV];

   logic                      w_found;
   logic [IDX_W-1:0]          w_win;
   logic [IDX_W:0]            w_sum;
   logic [IDX_W-1:0]          w_idx;
   logic                      w_elig;
   logic                      w_load_en;
   logic                      w_up_hs;
   logic                      w_fifo_full;
   logic [CNT_W-1:0]          w_fifo_count;

`ifdef AXI_AW_ARB_QOS_EN
   logic [3:0]                w_qos [NUM_SLV];
   logic [3:0]                w_max_qos;
   logic [3:0]                r_qos;
`endif

   // Split the flattened request buses into per-requester fields
   for (genvar g = 0; g < NUM_SLV; g++) begin : g_unpack
      assign w_addr[g] = slv_aw_addr_i[g*ADDRESS_WIDTH +: ADDRESS_WIDTH];
      assign w_len[g]  = slv_aw_len_i[g*8 +: 8];
      assign w_id[g]   = slv_aw_id_i[g*ID_WIDTH +: ID_WIDTH];
`ifdef AXI_AW_ARB_QOS_EN
      assign w_qos[g]  = slv_aw_qos_i[g*4 +: 4];
`endif
   end

   // Pick the first eligible requester searching upward from rr_ptr
   always_comb begin
      w_found = 1'b0;
      w_win   = '0;
      w_sum   = '0;
      w_idx   = '0;
      w_elig  = 1'b0;
`ifdef AXI_AW_ARB_QOS_EN
      w_max_qos = '0;
      for (int k = 0; k < NUM_SLV; k++) begin
         if (slv_aw_valid_i[k] && (w_qos[k] > w_max_qos)) begin
            w_max_qos = w_qos[k];
         end
      end
`endif
      for (int k = 0; k < NUM_SLV; k++) begin
         w_sum = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
         if (w_sum >= (IDX_W+1)'(NUM_SLV)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_SLV);
         end
         w_idx  = w_sum[IDX_W-1:0];
         w_elig = slv_aw_valid_i[w_idx];
`ifdef AXI_AW_ARB_QOS_EN
         w_elig = w_elig && (w_qos[w_idx] == w_max_qos);
`endif
         if (!w_found && w_elig) begin
            w_found = 1'b1;
            w_win   = w_idx;
         end
      end
   end

   // A new AW may enter when the stage frees up and a grant slot is left
   assign w_load_en = ((r_state == EMPTY) || mst_aw_ready_i) && !w_fifo_full;
   assign w_up_hs   = w_load_en && w_found;

   // Only the winner sees ready
   always_comb begin
      slv_aw_ready_o = '0;
      if (w_found) begin
         slv_aw_ready_o[w_win] = w_load_en;
      end
   end

   // Output stage next state
   always_comb begin
      w_state_d = r_state;
      case (r_state)
         EMPTY:   if (w_up_hs) w_state_d = FULL;
         FULL: begin
            if (w_up_hs)             w_state_d = FULL;
            else if (mst_aw_ready_i) w_state_d = EMPTY;
         end
         default: w_state_d = EMPTY;
      endcase
   end

   // Output stage state register
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) r_state <= EMPTY;
      else         r_state <= w_state_d;
   end

   // Capture the winning payload on every upstream handshake
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_addr <= '0;
         r_len  <= '0;
         r_id   <= '0;
`ifdef AXI_AW_ARB_QOS_EN
         r_qos  <= '0;
`endif
      end else if (w_up_hs) begin
         r_addr <= w_addr[w_win];
         r_len  <= w_len[w_win];
         r_id   <= {w_win, w_id[w_win]};
`ifdef AXI_AW_ARB_QOS_EN
         r_qos  <= w_qos[w_win];
`endif
      end
   end

   // Round-robin pointer moves just past the last winner
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_rr_ptr <= '0;
      end else if (w_up_hs) begin
         r_rr_ptr <= (w_win == IDX_W'(NUM_SLV - 1)) ? '0 : w_win + IDX_W'(1);
      end
   end

   axi_grant_fifo #(
      .WIDTH (IDX_W),
      .DEPTH (MAX_OUTSTANDING)
   ) u_grant_fifo (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .push_i  (w_up_hs),
      .data_i  (w_win),
      .pop_i   (w_last_hs_i),
      .head_o  (w_sel_o),
      .count_o (w_fifo_count),
      .full_o  (w_fifo_full)
   );

   assign w_sel_valid_o  = (w_fifo_count != '0);
   assign mst_aw_valid_o = (r_state == FULL);
   assign mst_aw_addr_o  = r_addr;
   assign mst_aw_len_o   = r_len;
   assign mst_aw_id_o    = r_id;
`ifdef AXI_AW_ARB_QOS_EN
   assign mst_aw_qos_o   = r_qos;
`endif

endmodule

`default_nettype wire

// File: tb/tb_axi_aw_arbiter.sv
// ============================================================================
//  Module      : tb_axi_aw_arbiter
//  Description : Directed self-checking bench for axi_aw_arbiter (default
//                build, four requesters, 32-bit address, 16-bit ID).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_axi_aw_arbiter;

   logic          clk_i;
   logic          rst_ni;
   logic [3:0]    slv_aw_valid_i;
   logic [127:0]  slv_aw_addr_i;
   logic [31:0]   slv_aw_len_i;
   logic [63:0]   slv_aw_id_i;
   logic [3:0]    slv_aw_ready_o;
   logic          mst_aw_valid_o;
   logic [31:0]   mst_aw_addr_o;
   logic [7:0]    mst_aw_len_o;
   logic [17:0]   mst_aw_id_o;
   logic          mst_aw_ready_i;
   logic [1:0]    w_sel_o;
   logic          w_sel_valid_o;
   logic          w_last_hs_i;

   int n_checks = 0;
   int n_fail   = 0;

   axi_aw_arbiter #(
      .NUM_SLV         (4),
      .ADDRESS_WIDTH   (32),
      .ID_WIDTH        (16),
      .MAX_OUTSTANDING (4)
   ) dut (
      .clk_i          (clk_i),
      .rst_ni         (rst_ni),
      .slv_aw_valid_i (slv_aw_valid_i),
      .slv_aw_addr_i  (slv_aw_addr_i),
      .slv_aw_len_i   (slv_aw_len_i),
      .slv_aw_id_i    (slv_aw_id_i),
      .slv_aw_ready_o (slv_aw_ready_o),
      .mst_aw_valid_o (mst_aw_valid_o),
      .mst_aw_addr_o  (mst_aw_addr_o),
      .mst_aw_len_o   (mst_aw_len_o),
      .mst_aw_id_o    (mst_aw_id_o),
      .mst_aw_ready_i (mst_aw_ready_i),
      .w_sel_o        (w_sel_o),
      .w_sel_valid_o  (w_sel_valid_o),
      .w_last_hs_i    (w_last_hs_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic set_req(input int i, input logic [31:0] a, input logic [7:0] l,
                          input logic [15:0] d);
      slv_aw_addr_i[i*32 +: 32] = a;
      slv_aw_len_i[i*8 +: 8]    = l;
      slv_aw_id_i[i*16 +: 16]   = d;
   endtask

   initial begin
      rst_ni         = 1'b0;
      slv_aw_valid_i = '0;
      slv_aw_addr_i  = '0;
      slv_aw_len_i   = '0;
      slv_aw_id_i    = '0;
      mst_aw_ready_i = 1'b0;
      w_last_hs_i    = 1'b0;

      // Reset state
      repeat (3) @(posedge clk_i);
      #1;
      chk("rst_mst_valid", 64'(mst_aw_valid_o), 64'd0);
      chk("rst_ready",     64'(slv_aw_ready_o), 64'd0);
      chk("rst_wsel_vld",  64'(w_sel_valid_o),  64'd0);
      chk("rst_wsel",      64'(w_sel_o),        64'd0);
      chk("rst_addr",      64'(mst_aw_addr_o),  64'd0);
      chk("rst_len",       64'(mst_aw_len_o),   64'd0);
      chk("rst_id",        64'(mst_aw_id_o),    64'd0);
      rst_ni = 1'b1;

      // Idle for ten cycles
      for (int c = 0; c < 10; c++) begin
         step();
         chk("idle_mst_valid", 64'(mst_aw_valid_o), 64'd0);
         chk("idle_ready",     64'(slv_aw_ready_o), 64'd0);
         chk("idle_wsel_vld",  64'(w_sel_valid_o),  64'd0);
      end

      // All four requesting continuously: grants 0,1,2,3,0
      for (int i = 0; i < 4; i++) begin
         set_req(i, 32'h1000_0000 + 32'(i * 256), 8'(i + 1), 16'(16'h0100 + i));
      end
      slv_aw_valid_i = 4'hF;
      mst_aw_ready_i = 1'b1;
      w_last_hs_i    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         chk("rr_ready", 64'(slv_aw_ready_o), 64'(4'b0001 << (k % 4)));
         if (k >= 1) chk("rr_id_idx", 64'(mst_aw_id_o[17:16]), 64'((k - 1) % 4));
         step();
      end
      chk("rr_id_idx_last", 64'(mst_aw_id_o[17:16]), 64'd0);
      chk("rr_addr_last",   64'(mst_aw_addr_o),      64'h1000_0000);
      chk("rr_wsel_vld",    64'(w_sel_valid_o),      64'd1);
      chk("rr_wsel",        64'(w_sel_o),            64'd0);
      slv_aw_valid_i = '0;
      step();
      w_last_hs_i = 1'b0;
      chk("rr_drain_valid", 64'(mst_aw_valid_o), 64'd0);
      chk("rr_drain_wsel",  64'(w_sel_valid_o),  64'd0);

      // Single requester 2, payload check (rr_ptr=1 here)
      set_req(2, 32'h8000_0040, 8'd3, 16'h00A5);
      slv_aw_valid_i = 4'b0100;
      #1;
      chk("r2_ready", 64'(slv_aw_ready_o), 64'b0100);
      step();
      chk("r2_valid", 64'(mst_aw_valid_o), 64'd1);
      chk("r2_addr",  64'(mst_aw_addr_o),  64'h8000_0040);
      chk("r2_len",   64'(mst_aw_len_o),   64'd3);
      chk("r2_id",    64'(mst_aw_id_o),    64'h2_00A5);
      chk("r2_wsel",  64'(w_sel_o),        64'd2);
      slv_aw_valid_i = '0;
      w_last_hs_i    = 1'b1;
      step();
      w_last_hs_i = 1'b0;
      chk("r2_empty",    64'(mst_aw_valid_o), 64'd0);
      chk("r2_wsel_vld", 64'(w_sel_valid_o),  64'd0);

      // Downstream stall with requester 1 valid (rr_ptr=3)
      set_req(1, 32'h1111_0000, 8'd7, 16'h0011);
      slv_aw_valid_i = 4'b0010;
      mst_aw_ready_i = 1'b0;
      #1;
      chk("stall_first_ready", 64'(slv_aw_ready_o), 64'b0010);
      step();
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("stall_ready", 64'(slv_aw_ready_o), 64'd0);
         chk("stall_valid", 64'(mst_aw_valid_o), 64'd1);
         chk("stall_addr",  64'(mst_aw_addr_o),  64'h1111_0000);
         chk("stall_id",    64'(mst_aw_id_o),    64'h1_0011);
         step();
      end
      slv_aw_valid_i = '0;
      mst_aw_ready_i = 1'b1;
      w_last_hs_i    = 1'b1;
      step();
      w_last_hs_i = 1'b0;
      chk("stall_release_valid", 64'(mst_aw_valid_o), 64'd0);
      chk("stall_single_push",   64'(w_sel_valid_o),  64'd0);

      // Fill grant FIFO (rr_ptr=2): grants 2,3,0,1 then blocked
      slv_aw_valid_i = 4'hF;
      for (int k = 0; k < 4; k++) begin
         #1;
         chk("fill_ready", 64'(slv_aw_ready_o), 64'(4'b0001 << ((2 + k) % 4)));
         step();
      end
      #1;
      chk("full_ready",  64'(slv_aw_ready_o),     64'd0);
      chk("full_wsel",   64'(w_sel_o),            64'd2);
      chk("full_valid",  64'(mst_aw_valid_o),     64'd1);
      chk("full_id_idx", 64'(mst_aw_id_o[17:16]), 64'd1);
      step();
      chk("full_drained", 64'(mst_aw_valid_o), 64'd0);
      chk("full_ready2",  64'(slv_aw_ready_o), 64'd0);
      w_last_hs_i = 1'b1;
      #1;
      chk("full_pop_ready", 64'(slv_aw_ready_o), 64'd0);
      step();
      w_last_hs_i = 1'b0;
      #1;
      chk("pop_wsel",   64'(w_sel_o),        64'd3);
      chk("pop_resume", 64'(slv_aw_ready_o), 64'b0100);
      slv_aw_valid_i = '0;
      step();
      w_last_hs_i = 1'b1;
      repeat (3) step();
      w_last_hs_i = 1'b0;
      #1;
      chk("fifo_emptied", 64'(w_sel_valid_o), 64'd0);

      // Two queued grants then reset mid-transfer (rr_ptr=2)
      slv_aw_valid_i = 4'b0011;
      #1;
      chk("pre_rst_ready0", 64'(slv_aw_ready_o), 64'b0001);
      step();
      #1;
      chk("pre_rst_ready1", 64'(slv_aw_ready_o), 64'b0010);
      step();
      mst_aw_ready_i = 1'b0;
      slv_aw_valid_i = '0;
      #1;
      chk("pre_rst_valid",   64'(mst_aw_valid_o), 64'd1);
      chk("pre_rst_wsel_vd", 64'(w_sel_valid_o),  64'd1);
      chk("pre_rst_wsel",    64'(w_sel_o),        64'd0);
      #2;
      rst_ni = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(mst_aw_valid_o), 64'd0);
      chk("mid_rst_wsel",  64'(w_sel_valid_o),  64'd0);
      chk("mid_rst_addr",  64'(mst_aw_addr_o),  64'd0);
      @(posedge clk_i);
      #1;
      rst_ni         = 1'b1;
      slv_aw_valid_i = 4'hF;
      mst_aw_ready_i = 1'b1;
      #1;
      chk("post_rst_ready", 64'(slv_aw_ready_o), 64'b0001);
      step();
      chk("post_rst_id_idx", 64'(mst_aw_id_o[17:16]), 64'd0);
      chk("post_rst_valid",  64'(mst_aw_valid_o),     64'd1);
      slv_aw_valid_i = '0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
